// File: rtl/uart_periph_if.sv
// uart_periph_if
//   Register-bus bundle between the peripheral bus master (CPU or debug
//   downloader) and the UART responder.
//   we_i   : write strobe, sampled at posedge clk
//   addr_i : byte address, responder decodes [7:0] only
//   data_i : write data
//   data_o : read data, combinational from addr_i
interface uart_periph_if;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;

    modport master (output we_i, output addr_i, output data_i, input data_o);
    modport slave  (input we_i, input addr_i, input data_i, output data_o);
endinterface

// File: rtl/uart_periph.sv
// uart_periph
//   Memory-mapped 8N1 UART: CTRL/STATUS/BAUD/TX/RX registers plus serial
//   transmit and receive engines.
//   Ports: clk, rstn (async active-low), bus (uart_periph_if.slave),
//          tx_pin (serial out, idle high), rx_pin (serial in, async),
//          irq_o (rx_over & rx_en).
//   Optional build macro UART_LOOPBACK_EN adds CTRL bit2 loop_en, which
//   routes the internal TX line into the RX engine and parks tx_pin high.
module uart_periph #(
    parameter logic [31:0] BAUD_RST = 32'h0000_01B8,
    parameter logic [31:0] MIN_DIV  = 32'd16
) (
    input  logic          clk,
    input  logic          rstn,
    uart_periph_if.slave  bus,
    output logic          tx_pin,
    input  logic          rx_pin,
    output logic          irq_o
);
`ifdef UART_LOOPBACK_EN
    localparam int CTRL_W = 3;
`else
    localparam int CTRL_W = 2;
`endif

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_e;

    logic [CTRL_W-1:0] r_ctrl;
    logic [31:0]       r_baud;
    logic              r_rx_over;
    logic [7:0]        r_rx_data;

    state_e      r_tx_state, w_tx_state_nxt;
    logic [31:0] r_tx_cnt, w_tx_cnt_nxt, r_tx_div, w_tx_div_nxt;
    logic [3:0]  r_tx_idx, w_tx_idx_nxt;
    logic [7:0]  r_tx_shift, w_tx_shift_nxt;
    logic        r_tx_line, w_tx_line_nxt;

    state_e      r_rx_state, w_rx_state_nxt;
    logic [31:0] r_rx_cnt, w_rx_cnt_nxt, r_rx_div, w_rx_div_nxt;
    logic [3:0]  r_rx_idx, w_rx_idx_nxt;
    logic [7:0]  r_rx_shift, w_rx_shift_nxt;
    logic        r_rx_s1, r_rx_s2, r_rx_prev;
    logic        w_rx_done, w_rx_in, w_rx_fall;

    logic [7:0]  w_off;
    logic [31:0] w_div_eff, w_rdata;
    logic        w_wr_ctrl, w_wr_status, w_wr_baud, w_wr_tx, w_tx_go, w_tx_busy;
    logic        w_unused_addr;

    assign w_off         = bus.addr_i[7:0];
    assign w_unused_addr = ^bus.addr_i[31:8];
    assign w_wr_ctrl     = bus.we_i && (w_off == 8'h00);
    assign w_wr_status   = bus.we_i && (w_off == 8'h04);
    assign w_wr_baud     = bus.we_i && (w_off == 8'h08);
    assign w_wr_tx       = bus.we_i && (w_off == 8'h0C);
    assign w_div_eff     = (r_baud < MIN_DIV) ? MIN_DIV : r_baud;
    assign w_tx_busy     = (r_tx_state != ST_IDLE);
    assign w_tx_go       = w_wr_tx && r_ctrl[0] && !w_tx_busy;
    assign w_rx_fall     = r_rx_prev && !r_rx_s2;
    assign irq_o         = r_rx_over && r_ctrl[1];

`ifdef UART_LOOPBACK_EN
    logic r_loop_act;

    // Loopback select follows loop_en only while both engines are idle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_loop_act <= 1'b0;
        end else if ((r_tx_state == ST_IDLE) && (r_rx_state == ST_IDLE)) begin
            r_loop_act <= r_ctrl[2];
        end
    end

    assign w_rx_in = r_loop_act ? r_tx_line : rx_pin;
    assign tx_pin  = r_loop_act ? 1'b1 : r_tx_line;
`else
    assign w_rx_in = rx_pin;
    assign tx_pin  = r_tx_line;
`endif

    // Software-visible registers; a received byte beats a same-cycle clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ctrl    <= '0;
            r_baud    <= BAUD_RST;
            r_rx_over <= 1'b0;
            r_rx_data <= 8'h00;
        end else begin
            if (w_wr_ctrl) r_ctrl <= bus.data_i[CTRL_W-1:0];
            if (w_wr_baud) r_baud <= bus.data_i;
            if (w_rx_done) begin
                r_rx_over <= 1'b1;
                r_rx_data <= r_rx_shift;
            end else if (w_wr_status && !bus.data_i[1]) begin
                r_rx_over <= 1'b0;
            end
        end
    end

    // Zero-latency read mux.
    always_comb begin
        w_rdata = 32'h0000_0000;
        case (w_off)
            8'h00:   w_rdata = {{(32-CTRL_W){1'b0}}, r_ctrl};
            8'h04:   w_rdata = {30'h0, r_rx_over, w_tx_busy};
            8'h08:   w_rdata = r_baud;
            8'h10:   w_rdata = {24'h0, r_rx_data};
            default: w_rdata = 32'h0000_0000;
        endcase
    end
    assign bus.data_o = w_rdata;

    // TX engine state and datapath registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_tx_state <= ST_IDLE;
            r_tx_cnt   <= 32'd0;
            r_tx_div   <= 32'd0;
            r_tx_idx   <= 4'd0;
            r_tx_shift <= 8'h00;
            r_tx_line  <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_tx_cnt   <= w_tx_cnt_nxt;
            r_tx_div   <= w_tx_div_nxt;
            r_tx_idx   <= w_tx_idx_nxt;
            r_tx_shift <= w_tx_shift_nxt;
            r_tx_line  <= w_tx_line_nxt;
        end
    end

    // TX next state: the line value is registered alongside the state so
    // each bit is held for exactly one divider period.
    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_cnt_nxt   = r_tx_cnt;
        w_tx_div_nxt   = r_tx_div;
        w_tx_idx_nxt   = r_tx_idx;
        w_tx_shift_nxt = r_tx_shift;
        w_tx_line_nxt  = r_tx_line;
        case (r_tx_state)
            ST_IDLE: begin
                w_tx_line_nxt = 1'b1;
                if (w_tx_go) begin
                    w_tx_state_nxt = ST_START;
                    w_tx_div_nxt   = w_div_eff;
                    w_tx_cnt_nxt   = w_div_eff - 32'd1;
                    w_tx_shift_nxt = bus.data_i[7:0];
                    w_tx_line_nxt  = 1'b0;
                end else begin
                    w_tx_state_nxt = ST_IDLE;
                end
            end
            ST_START: begin
                if (r_tx_cnt == 32'd0) begin
                    w_tx_state_nxt = ST_DATA;
                    w_tx_cnt_nxt   = r_tx_div - 32'd1;
                    w_tx_idx_nxt   = 4'd0;
                    w_tx_line_nxt  = r_tx_shift[0];
                end else begin
                    w_tx_cnt_nxt   = r_tx_cnt - 32'd1;
                end
            end
            ST_DATA: begin
                if (r_tx_cnt == 32'd0) begin
                    w_tx_cnt_nxt = r_tx_div - 32'd1;
                    if (r_tx_idx == 4'd7) begin
                        w_tx_state_nxt = ST_STOP;
                        w_tx_line_nxt  = 1'b1;
                    end else begin
                        w_tx_idx_nxt   = r_tx_idx + 4'd1;
                        w_tx_shift_nxt = {1'b0, r_tx_shift[7:1]};
                        w_tx_line_nxt  = r_tx_shift[1];
                    end
                end else begin
                    w_tx_cnt_nxt = r_tx_cnt - 32'd1;
                end
            end
            ST_STOP: begin
                if (r_tx_cnt == 32'd0) begin
                    w_tx_state_nxt = ST_IDLE;
                    w_tx_line_nxt  = 1'b1;
                end else begin
                    w_tx_cnt_nxt = r_tx_cnt - 32'd1;
                end
            end
            default: begin
                w_tx_state_nxt = ST_IDLE;
                w_tx_line_nxt  = 1'b1;
            end
        endcase
    end

    // RX synchronizer, edge-detect history and engine registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_state <= ST_IDLE;
            r_rx_cnt   <= 32'd0;
            r_rx_div   <= 32'd0;
            r_rx_idx   <= 4'd0;
            r_rx_shift <= 8'h00;
        end else begin
            r_rx_s1    <= w_rx_in;
            r_rx_s2    <= r_rx_s1;
            r_rx_prev  <= r_rx_s2;
            r_rx_state <= w_rx_state_nxt;
            r_rx_cnt   <= w_rx_cnt_nxt;
            r_rx_div   <= w_rx_div_nxt;
            r_rx_idx   <= w_rx_idx_nxt;
            r_rx_shift <= w_rx_shift_nxt;
        end
    end

    // RX next state: first sample at half a bit, then one per bit period.
    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rx_cnt_nxt   = r_rx_cnt;
        w_rx_div_nxt   = r_rx_div;
        w_rx_idx_nxt   = r_rx_idx;
        w_rx_shift_nxt = r_rx_shift;
        w_rx_done      = 1'b0;
        case (r_rx_state)
            ST_IDLE: begin
                if (r_ctrl[1] && w_rx_fall) begin
                    w_rx_state_nxt = ST_START;
                    w_rx_div_nxt   = w_div_eff;
                    w_rx_cnt_nxt   = (w_div_eff >> 1) - 32'd1;
                end else begin
                    w_rx_state_nxt = ST_IDLE;
                end
            end
            ST_START: begin
                if (r_rx_cnt == 32'd0) begin
                    if (r_rx_s2) begin
                        w_rx_state_nxt = ST_IDLE;
                    end else begin
                        w_rx_state_nxt = ST_DATA;
                        w_rx_cnt_nxt   = r_rx_div - 32'd1;
                        w_rx_idx_nxt   = 4'd0;
                    end
                end else begin
                    w_rx_cnt_nxt = r_rx_cnt - 32'd1;
                end
            end
            ST_DATA: begin
                if (r_rx_cnt == 32'd0) begin
                    w_rx_shift_nxt = {r_rx_s2, r_rx_shift[7:1]};
                    w_rx_cnt_nxt   = r_rx_div - 32'd1;
                    if (r_rx_idx == 4'd7) begin
                        w_rx_state_nxt = ST_STOP;
                    end else begin
                        w_rx_idx_nxt = r_rx_idx + 4'd1;
                    end
                end else begin
                    w_rx_cnt_nxt = r_rx_cnt - 32'd1;
                end
            end
            ST_STOP: begin
                if (r_rx_cnt == 32'd0) begin
                    w_rx_state_nxt = ST_IDLE;
                    w_rx_done      = r_rx_s2;
                end else begin
                    w_rx_cnt_nxt = r_rx_cnt - 32'd1;
                end
            end
            default: begin
                w_rx_state_nxt = ST_IDLE;
            end
        endcase
    end
endmodule
